axis_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXIS write port, normally the slave side of an axis_data_fifo, between NUM_REQ AXIS requesters.
- A grant is held for a burst of up to MAX_BURST beats, then rotates to the next requester.
- One registered output stage; the tready path passes combinationally from m_axis_tready.
- Sits entirely in the FIFO write clock domain.

---
 rtl/axis_rr_arbiter_pkg.sv | 40 ++++
 rtl/axis_rr_arbiter_if.sv | 43 ++++
 rtl/axis_rr_arbiter_pick.sv | 26 ++
 rtl/axis_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and the round-robin pick helper
// for the AXIS round-robin arbiter.
package axis_arb_pkg;

   localparam int MAX_REQ = 16;
   localparam int PICK_W  = 4;

   typedef enum logic {
      ARB,
      GRANT
   } arb_state_t;

   typedef struct packed {
      logic              found;
      logic [PICK_W-1:0] idx;
   } pick_t;

   // First set bit of req searching last+1, last+2, ...
   // with wrap modulo n.
   function automatic pick_t rr_pick(
      input logic [MAX_REQ-1:0] req,
      input logic [PICK_W-1:0]  last,
      input int                 n
   );
      pick_t             r;
      logic [PICK_W-1:0] j;
      r = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         if (k <= n && !r.found) begin
            j = PICK_W'((int'(last) + k) % n);
            if (req[j]) begin
               r.found = 1'b1;
               r.idx   = j;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Requester, downstream and grant-status signals
// of the AXIS round-robin arbiter.
interface axis_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0]            s_axis_tvalid;
   logic [NUM_REQ-1:0]            s_axis_tready;
   logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;
   logic [DATA_WIDTH-1:0]         m_axis_tdata;
   logic [ID_WIDTH-1:0]           m_axis_tid;
   logic                          grant_valid;
   logic [ID_WIDTH-1:0]           grant_id;

   modport master (
      input  s_axis_tvalid,
      input  s_axis_tdata,
      input  m_axis_tready,
      output s_axis_tready,
      output m_axis_tvalid,
      output m_axis_tdata,
      output m_axis_tid,
      output grant_valid,
      output grant_id
   );

   modport slave (
      output s_axis_tvalid,
      output s_axis_tdata,
      output m_axis_tready,
      input  s_axis_tready,
      input  m_axis_tvalid,
      input  m_axis_tdata,
      input  m_axis_tid,
      input  grant_valid,
      input  grant_id
   );

endinterface

// File: rtl/axis_rr_arbiter_pick.sv
// Rotating-priority encoder: first request
// after last_grant_i, wrapping around.
module rr_priority_pick
   import axis_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [ID_WIDTH-1:0] last_grant_i,
   output logic [ID_WIDTH-1:0] idx_o,
   output logic                found_o
);

   pick_t pick;

   // Evaluate the package helper on widened inputs
   always_comb begin
      pick    = rr_pick(MAX_REQ'(req_i),
                        PICK_W'(last_grant_i),
                        NUM_REQ);
      idx_o   = ID_WIDTH'(pick.idx);
      found_o = pick.found;
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ AXIS streams
// into one registered AXIS write port.
module axis_rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input logic               axis_clk,
   input logic               axis_rst_n,
   axis_rr_arbiter_if.master bus
);

   localparam int ID_WIDTH = $clog2(NUM_REQ);
   localparam int CW       = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST_BEAT =
      CW'(MAX_BURST - 1);
   localparam logic [ID_WIDTH-1:0] LAST_ID =
      ID_WIDTH'(NUM_REQ - 1);

   arb_state_t            state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [ID_WIDTH-1:0]   last_q, last_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]   pick_idx;
   logic                  pick_found;
   logic                  out_free;
   logic                  accept;
   logic [NUM_REQ-1:0]    ready;
   logic                  vld_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ID_WIDTH-1:0]   tid_q;

   rr_priority_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .req_i        (bus.s_axis_tvalid),
      .last_grant_i (last_q),
      .idx_o        (pick_idx),
      .found_o      (pick_found)
   );

   // Arbitration state, grant and burst counter
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= ARB;
         grant_q <= '0;
         last_q  <= LAST_ID;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pick in ARB; count beats and release in GRANT
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ARB: begin
            if (pick_found) begin
               grant_d = pick_idx;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = ARB;
                  last_d  = grant_q;
               end
            end else if (!bus.s_axis_tvalid[grant_q]) begin
               state_d = ARB;
               last_d  = grant_q;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Ready only to the granted port while output can take a beat
   always_comb begin
      out_free = !vld_q || bus.m_axis_tready;
      ready    = '0;
      if (state_q == GRANT) begin
         ready[grant_q] = out_free;
      end
      accept = bus.s_axis_tvalid[grant_q] && ready[grant_q];
   end

   // Output register: load on accept, clear when drained
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         tid_q  <= '0;
      end else if (accept) begin
         vld_q  <= 1'b1;
         data_q <= bus.s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
         tid_q  <= grant_q;
      end else if (vld_q && bus.m_axis_tready) begin
         vld_q  <= 1'b0;
      end
   end

   assign bus.s_axis_tready = ready;
   assign bus.m_axis_tvalid = vld_q;
   assign bus.m_axis_tdata  = data_q;
   assign bus.m_axis_tid    = tid_q;
   assign bus.grant_valid   = (state_q == GRANT);
   assign bus.grant_id      = grant_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed
// scenarios plus randomized valid/ready traffic.
module tb_axis_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int IW = 2;
   localparam int WAIT_MAX = N * (MB + 1) + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   axis_rr_arbiter_if #(
      .NUM_REQ(N),
      .DATA_WIDTH(DW)
   ) bus ();

   axis_rr_arbiter #(
      .NUM_REQ(N),
      .DATA_WIDTH(DW),
      .MAX_BURST(MB)
   ) dut (
      .axis_clk   (clk),
      .axis_rst_n (rst_n),
      .bus        (bus.master)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act,
                      input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   logic [DW-1:0] sq[N][$];
   logic [N-1:0]  vld;
   logic [DW-1:0] dat[N];
   logic [DW-1:0] dcnt[N];
   int            n_left[N];
   bit            acc[N];
   int            p_valid = 100;
   int            p_ready = 100;
   bit            rnd_data = 1'b0;

   int            log_t[$];
   int            log_c[$];
   logic [DW-1:0] log_d[$];

   task automatic drive();
      bus.s_axis_tvalid = vld;
      for (int i = 0; i < N; i++)
         bus.s_axis_tdata[i*DW +: DW] = dat[i];
   endtask

   // One cycle: new inputs at negedge, record input handshakes
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!(vld[i] && !acc[i])) begin
            if (n_left[i] > 0 &&
                $urandom_range(99) < p_valid) begin
               vld[i] = 1'b1;
               dat[i] = rnd_data ? DW'($urandom) : dcnt[i];
               dcnt[i]++;
               n_left[i]--;
            end else begin
               vld[i] = 1'b0;
            end
         end
      end
      drive();
      bus.m_axis_tready = ($urandom_range(99) < p_ready);
      #1;
      for (int i = 0; i < N; i++) begin
         acc[i] = vld[i] && bus.s_axis_tready[i];
         if (acc[i]) sq[i].push_back(dat[i]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
      chk("rst_m_tdata", bus.m_axis_tdata, 0);
      chk("rst_m_tid", bus.m_axis_tid, 0);
      chk("rst_s_tready", bus.s_axis_tready, 0);
      chk("rst_grant_valid", bus.grant_valid, 0);
      chk("rst_grant_id", bus.grant_id, 0);
      vld = '0;
      for (int i = 0; i < N; i++) begin
         acc[i] = 1'b0;
         n_left[i] = 0;
         sq[i].delete();
      end
      drive();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      log_t.delete();
      log_c.delete();
      log_d.delete();
   endtask

   task automatic drain();
      int pend;
      for (int i = 0; i < N; i++) n_left[i] = 0;
      p_ready = 100;
      pend = 1;
      for (int s = 0; s < 200 && pend != 0; s++) begin
         step();
         pend = int'(vld != 0) + int'(bus.m_axis_tvalid);
         for (int i = 0; i < N; i++)
            pend += sq[i].size();
      end
      chk("drain_empty", pend, 0);
   endtask

   // Monitor: grant-order model, release rule, scoreboard pops
   int            cyc = 0;
   logic [N-1:0]  prev_tv;
   bit            prev_gv;
   logic [IW-1:0] prev_gid;
   int            model_last;
   int            beats;
   int            wcnt[N];

   always @(negedge clk) begin : mon
      logic [N-1:0] tv;
      logic [N-1:0] rd;
      int exp_id;
      int j;
      int t;
      int got;
      logic [DW-1:0] e;
      #2;
      cyc++;
      tv = bus.s_axis_tvalid;
      rd = bus.s_axis_tready;
      if (!rst_n) begin
         prev_gv = 1'b0;
         prev_tv = tv;
         prev_gid = '0;
         model_last = N - 1;
         beats = 0;
         for (int i = 0; i < N; i++) wcnt[i] = 0;
      end else begin
         chk("ready_onehot", int'($countones(rd) <= 1), 1);
         if (rd != 0)
            chk("ready_is_grant", int'(rd),
                bus.grant_valid ? (1 << bus.grant_id) : 0);
         if (bus.grant_valid && !prev_gv) begin
            exp_id = -1;
            for (int k = 1; k <= N; k++) begin
               j = (model_last + k) % N;
               if (exp_id < 0 && prev_tv[j]) exp_id = j;
            end
            chk("grant_order", int'(bus.grant_id), exp_id);
            beats = 0;
         end
         if (!bus.grant_valid && prev_gv) begin
            chk("release_rule",
                int'(beats == MB || !prev_tv[prev_gid]), 1);
            model_last = int'(prev_gid);
         end
         if (bus.grant_valid &&
             tv[bus.grant_id] && rd[bus.grant_id]) begin
            beats++;
            chk("burst_len", int'(beats <= MB), 1);
         end
         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            t = int'(bus.m_axis_tid);
            got = sq[t].size();
            chk("sb_pending", int'(got > 0), 1);
            if (got > 0) begin
               e = sq[t].pop_front();
               chk("sb_data", bus.m_axis_tdata, e);
            end
            log_t.push_back(t);
            log_c.push_back(cyc);
            log_d.push_back(bus.m_axis_tdata);
         end
         for (int i = 0; i < N; i++) begin
            if (tv[i] && rd[i]) begin
               chk("wait_bound", int'(wcnt[i] <= WAIT_MAX), 1);
               wcnt[i] = 0;
            end else if (!tv[i]) begin
               wcnt[i] = 0;
            end else if (!(bus.m_axis_tvalid &&
                           !bus.m_axis_tready)) begin
               wcnt[i]++;
            end
         end
         prev_tv = tv;
         prev_gv = bus.grant_valid;
         prev_gid = bus.grant_id;
      end
   end

   logic [DW-1:0] held;

   initial begin
      vld = '0;
      for (int i = 0; i < N; i++) begin
         dat[i] = '0;
         dcnt[i] = '0;
         n_left[i] = 0;
         acc[i] = 1'b0;
      end
      drive();
      bus.m_axis_tready = 1'b0;

      // Single requester 1: burst of 4, bubble, 5th beat
      do_reset();
      p_valid = 100;
      p_ready = 100;
      n_left[1] = 5;
      dcnt[1] = 8'h11;
      step();
      chk("t1_arb_cycle", bus.grant_valid, 0);
      step();
      chk("t1_grant_valid", bus.grant_valid, 1);
      chk("t1_grant_id", bus.grant_id, 1);
      for (int s = 0; s < 40 && log_d.size() < 5; s++)
         step();
      chk("t1_beats", log_d.size(), 5);
      if (log_d.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t1_data", log_d[i], 8'h11 + i);
            chk("t1_tid", log_t[i], 1);
         end
         for (int i = 1; i < 5; i++)
            chk("t1_gap", log_c[i] - log_c[i-1],
                (i == 4) ? 2 : 1);
      end
      drain();

      // All four continuously valid: 4-beat bursts in order
      do_reset();
      for (int i = 0; i < N; i++) begin
         n_left[i] = 8;
         dcnt[i] = 8'(8'h80 + 16 * i);
      end
      repeat (30) step();
      chk("t2_beats_ge17", int'(log_t.size() >= 17), 1);
      if (log_t.size() >= 17) begin
         for (int i = 0; i < 16; i++)
            chk("t2_tid", log_t[i], i / 4);
         chk("t2_span", log_c[15] - log_c[0], 18);
         chk("t2_bubble", log_c[16] - log_c[15], 2);
      end
      drain();

      // Backpressure on requester 2
      do_reset();
      n_left[2] = 4;
      dcnt[2] = 8'h20;
      for (int s = 0; s < 10 && !bus.m_axis_tvalid; s++)
         step();
      chk("t3_first_beat", bus.m_axis_tvalid, 1);
      p_ready = 0;
      held = '0;
      for (int s = 0; s < 5; s++) begin
         step();
         if (s == 0) held = bus.m_axis_tdata;
         chk("t3_hold_data", bus.m_axis_tdata, held);
         chk("t3_hold_valid", bus.m_axis_tvalid, 1);
         chk("t3_ready2_low", bus.s_axis_tready[2], 0);
      end
      p_ready = 100;
      repeat (12) step();
      chk("t3_beats", log_d.size(), 4);
      if (log_d.size() == 4)
         for (int i = 0; i < 4; i++)
            chk("t3_data", log_d[i], 8'h20 + i);
      drain();

      // Requester 0 goes idle after 2 beats, 3 waiting
      do_reset();
      n_left[0] = 2;
      dcnt[0] = 8'h40;
      n_left[3] = 3;
      dcnt[3] = 8'h70;
      repeat (20) step();
      chk("t4_beats", log_t.size(), 5);
      if (log_t.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            chk("t4_tid", log_t[i], (i < 2) ? 0 : 3);
            chk("t4_data", log_d[i],
                (i < 2) ? 8'h40 + i : 8'h70 + i - 2);
         end
      end
      drain();

      // Reset in the middle of a burst of requester 2
      do_reset();
      n_left[2] = 8;
      dcnt[2] = 8'h50;
      for (int s = 0; s < 10 && !bus.m_axis_tvalid; s++)
         step();
      chk("t5_busy", bus.m_axis_tvalid, 1);
      do_reset();
      n_left[0] = 4;
      n_left[2] = 4;
      step();
      step();
      chk("t5_grant_valid", bus.grant_valid, 1);
      chk("t5_grant_id0", bus.grant_id, 0);
      drain();

      // Random traffic
      rnd_data = 1'b1;
      for (int c = 0; c < 20; c++) begin
         p_valid = int'($urandom_range(100, 20));
         p_ready = int'($urandom_range(100, 10));
         for (int i = 0; i < N; i++) n_left[i] = 1000000;
         repeat (500) step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
